popcount_sequencer: RTL

POPCOUNT_SEQUENCER -- requirements
Module: popcount_sequencer

---
 rtl/popcount_sequencer.sv | 71 +++++++
 1 files changed

// File: rtl/popcount_sequencer.sv
// popcount_sequencer: counts the 1 bits of a captured word one nibble per cycle and keeps a saturating running total
// Ports: clk/rst (async active-high) | start+data_in: request, taken only while ready
//        clear_total: sync zero of total | ready (IDLE), busy (RUN/DONE), done (one-cycle pulse)
//        count: ones in last accepted word | total: saturating sum of counts since reset/clear
module popcount_sequencer #(
  parameter int NIBBLES = 4,
  parameter int TOTAL_W = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [4*NIBBLES-1:0]               data_in,
  input  logic                               clear_total,
  output logic                               ready,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(4*NIBBLES+1)-1:0]     count,
  output logic [TOTAL_W-1:0]                 total
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(W + 1);
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam int SW = (TOTAL_W > CW ? TOTAL_W : CW) + 1;
  localparam logic [SW-1:0] MAX = SW'((64'd1 << TOTAL_W) - 64'd1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, next;
  logic [W-1:0] word;
  logic [IW-1:0] idx;
  logic [CW-1:0] acc, pc;
  logic [3:0] nib;
  logic last;
  logic [SW-1:0] sum;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  always_comb begin
    ready = state == IDLE;
    busy  = state != IDLE;
    done  = state == DONE;
  end
  // Clear is applied before the DONE-exit add, so a coincident clear leaves just this word's count.
  always_comb begin
    nib  = word[4*idx +: 4];
    pc   = CW'(nib[0]) + CW'(nib[1]) + CW'(nib[2]) + CW'(nib[3]);
    last = idx == IW'(NIBBLES - 1);
    sum  = SW'(clear_total ? '0 : total) + SW'(count);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      word  <= '0;
      idx   <= '0;
      acc   <= '0;
      count <= '0;
      total <= '0;
    end else begin
      if (state == IDLE && start) begin
        word <= data_in;
        idx  <= '0;
        acc  <= '0;
      end
      if (state == RUN) begin
        acc <= acc + pc;
        idx <= idx + IW'(1);
        if (last) count <= acc + pc;
      end
      if (state == DONE) total <= sum > MAX ? MAX[TOTAL_W-1:0] : sum[TOTAL_W-1:0];
      else if (clear_total) total <= '0;
    end
endmodule
